// File: rtl/muldiv_ctrl.sv
// Sequencer for the combinational HI/LO multiply/divide datapath: latches operands,
// holds them for a multicycle window, applies signed-multiply correction and owns HI/LO.
module muldiv_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [1:0]  md_sel,
  input  logic [31:0] md_lo,
  input  logic [31:0] md_hi
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  localparam logic [1:0] SelMulU = 2'b00;
  localparam logic [1:0] SelDivU = 2'b01;
  localparam logic [1:0] SelDivS = 2'b10;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            neg_q;

  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic [63:0] prod_neg;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign rs_abs   = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign rt_abs   = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign prod_neg = ~{md_hi, md_lo} + 64'd1;

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      md_a     <= 32'd0;
      md_b     <= 32'd0;
      md_sel   <= SelMulU;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (op)
              OpMult: begin
                md_a    <= rs_abs;
                md_b    <= rt_abs;
                md_sel  <= SelMulU;
                neg_q   <= rs_val[31] ^ rt_val[31];
                cnt_q   <= MulLoad;
                state_q <= StCalc;
              end
              OpMultu: begin
                md_a    <= rs_val;
                md_b    <= rt_val;
                md_sel  <= SelMulU;
                neg_q   <= 1'b0;
                cnt_q   <= MulLoad;
                state_q <= StCalc;
              end
              OpDiv, OpDivu: begin
                if (rt_val == 32'd0) begin
                  done     <= 1'b1;
                  div_zero <= 1'b1;
                end else begin
                  md_a    <= rs_val;
                  md_b    <= rt_val;
                  md_sel  <= (op == OpDiv) ? SelDivS : SelDivU;
                  neg_q   <= 1'b0;
                  cnt_q   <= DivLoad;
                  state_q <= StCalc;
                end
              end
              OpMthi: hi <= rs_val;
              OpMtlo: lo <= rs_val;
              default: ;
            endcase
          end
        end
        StCalc: begin
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          {hi, lo} <= neg_q ? prod_neg : {md_hi, md_lo};
          done     <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus queues expected results, a monitor checks
// each done pulse against them; a behavioural datapath closes the loop.
module tb_muldiv_ctrl;

  localparam int unsigned MulN = 4;
  localparam int unsigned DivN = 8;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo, md_a, md_b, md_lo, md_hi;
  logic [1:0]  md_sel;
  logic [63:0] dp;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy_n;
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    bit          chk_md;
    int          e0;
  } exp_t;

  exp_t sb_q[$];

  // Monitor state
  exp_t        me;
  logic [31:0] cap_a, cap_b;
  logic [1:0]  cap_s;
  int          busy_cnt = 0;
  int          stab_err = 0;
  logic        busy_prev = 1'b0;

  muldiv_ctrl #(
    .MUL_CYCLES(MulN),
    .DIV_CYCLES(DivN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo),
    .md_a    (md_a),
    .md_b    (md_b),
    .md_sel  (md_sel),
    .md_lo   (md_lo),
    .md_hi   (md_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational datapath the controller sequences.
  always_comb begin
    dp = 64'd0;
    case (md_sel)
      2'b00: dp = {32'd0, md_a} * {32'd0, md_b};
      2'b01: if (md_b != 32'd0) dp = {md_a % md_b, md_a / md_b};
      2'b10: begin
        if (md_b != 32'd0 && !(md_a == 32'h8000_0000 && md_b == 32'hFFFF_FFFF))
          dp = {32'($signed(md_a) % $signed(md_b)), 32'($signed(md_a) / $signed(md_b))};
      end
      default: ;
    endcase
    md_hi = dp[63:32];
    md_lo = dp[31:0];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    check({pfx, ":busy"}, {63'd0, busy}, 64'd0);
    check({pfx, ":done"}, {63'd0, done}, 64'd0);
    check({pfx, ":div_zero"}, {63'd0, div_zero}, 64'd0);
    check({pfx, ":hi"}, {32'd0, hi}, 64'd0);
    check({pfx, ":lo"}, {32'd0, lo}, 64'd0);
    check({pfx, ":md_a"}, {32'd0, md_a}, 64'd0);
    check({pfx, ":md_b"}, {32'd0, md_b}, 64'd0);
    check({pfx, ":md_sel"}, {62'd0, md_sel}, 64'd0);
  endtask

  // Issues one request, queues its expected outcome and waits for the monitor to retire it.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int n, input logic [1:0] esel,
                        input bit poke_busy);
    exp_t e;
    @(negedge clk);
    e.name   = name;
    e.hi     = ehi;
    e.lo     = elo;
    e.dz     = edz;
    e.lat    = edz ? 0 : n + 1;
    e.busy_n = edz ? 0 : n + 1;
    e.sel    = esel;
    e.a      = (o == OpMult && a[31]) ? (~a + 32'd1) : a;
    e.b      = (o == OpMult && b[31]) ? (~b + 32'd1) : b;
    e.chk_md = !edz;
    e.e0     = cyc + 1;
    sb_q.push_back(e);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start = 1'b0;
    if (poke_busy) begin
      @(negedge clk);
      $display("[TB] note: start issued while busy (must be ignored)");
      start  = 1'b1;
      op     = OpDivu;
      rs_val = 32'd7;
      rt_val = 32'd0;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt  = 0;
        stab_err  = 0;
        busy_prev = 1'b0;
      end else begin
        if (busy) begin
          if (!busy_prev) begin
            cap_a = md_a;
            cap_b = md_b;
            cap_s = md_sel;
          end else if ({md_a, md_b, md_sel} !== {cap_a, cap_b, cap_s}) begin
            stab_err++;
          end
          busy_cnt++;
        end
        busy_prev = busy;
        if (done) begin
          if (sb_q.size() == 0) begin
            check("spurious_done", {63'd0, done}, 64'd0);
          end else begin
            me = sb_q.pop_front();
            check({me.name, ":hi"}, {32'd0, hi}, {32'd0, me.hi});
            check({me.name, ":lo"}, {32'd0, lo}, {32'd0, me.lo});
            check({me.name, ":div_zero"}, {63'd0, div_zero}, {63'd0, me.dz});
            check({me.name, ":latency"}, 64'(cyc - me.e0), 64'(me.lat));
            check({me.name, ":busy_cycles"}, 64'(busy_cnt), 64'(me.busy_n));
            check({me.name, ":md_stable"}, 64'(stab_err), 64'd0);
            if (me.chk_md) begin
              check({me.name, ":md_sel"}, {62'd0, md_sel}, {62'd0, me.sel});
              check({me.name, ":md_a"}, {32'd0, md_a}, {32'd0, me.a});
              check({me.name, ":md_b"}, {32'd0, md_b}, {32'd0, me.b});
            end
          end
          busy_cnt = 0;
          stab_err = 0;
        end else if (div_zero) begin
          check("stray_div_zero", {63'd0, div_zero}, 64'd0);
        end else if (sb_q.size() != 0 && cyc - sb_q[0].e0 > 40) begin
          tests++;
          fails++;
          $display("FAIL %s:timeout got no done, expected done within 40 cycles", sb_q[0].name);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Stimulus
  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           1'b0, MulN, 2'b00, 1'b0);
    run_op("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
           1'b0, MulN, 2'b00, 1'b0);
    run_op("mult_min", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,
           1'b0, MulN, 2'b00, 1'b0);
    run_op("mult_mixed", OpMult, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6,
           1'b0, MulN, 2'b00, 1'b0);
    run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           1'b0, DivN, 2'b10, 1'b0);
    run_op("divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DivN, 2'b01, 1'b0);

    mt(OpMthi, 32'h1234);
    check("mthi:hi", {32'd0, hi}, 64'h1234);
    check("mthi:busy", {63'd0, busy}, 64'd0);
    mt(OpMtlo, 32'h5678);
    check("mtlo:lo", {32'd0, lo}, 64'h5678);
    check("mtlo:hi_kept", {32'd0, hi}, 64'h1234);

    run_op("divu_zero", OpDivu, 32'd7, 32'd0, 32'h1234, 32'h5678, 1'b1, 0, 2'b00, 1'b0);

    // Reset in the middle of CALC of an unqueued MULTU 2x3.
    @(negedge clk);
    start  = 1'b1;
    op     = OpMultu;
    rs_val = 32'd2;
    rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst:busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_abort:hi", {32'd0, hi}, 64'd0);
    check("rst_abort:lo", {32'd0, lo}, 64'd0);

    run_op("multu_after_rst", OpMultu, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, MulN, 2'b00, 1'b0);
    run_op("busy_ignore", OpMultu, 32'd9, 32'd11, 32'd0, 32'd99, 1'b0, MulN, 2'b00, 1'b1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
